// File: rtl/g15_mem_pkg.sv
// Geometry defaults, index types and host-port types shared by the G-15 drum line bank.
package g15_mem_pkg;

    localparam int G15_LONG_WORDS = 108;
    localparam int G15_BITS       = 29;

    // Index width for a range of n values; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [$clog2(G15_BITS)-1:0]       digit_t;
    typedef logic [$clog2(G15_LONG_WORDS)-1:0] word_t;
    typedef logic [1:0]                        line_t;

    typedef enum logic [1:0] {
        H_IDLE     = 2'd0,
        H_PENDING  = 2'd1,
        H_ACK      = 2'd2,
        H_WAIT_LOW = 2'd3
    } host_state_e;

    // Host request at the default drum geometry.
    typedef struct packed {
        logic                we;
        line_t               line;
        word_t               word;
        logic [G15_BITS-1:0] wdata;
    } host_req_t;

endpackage

// File: rtl/mem_line.sv
// One drum line: word RAM, current-word shift buffer, next-word prefetch and write-back.
module mem_line
    import g15_mem_pkg::*;
#(
    parameter int WORDS = G15_LONG_WORDS,
    parameter int BITS  = G15_BITS,
    parameter int WW    = idx_width(WORDS),
    parameter int DW    = idx_width(BITS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bit_en,
    input  logic [DW-1:0]   digit,
    input  logic [WW-1:0]   word,
    input  logic [WW-1:0]   word_nxt,
    input  logic [WW-1:0]   word_nxt2,
    input  logic            wr_en,
    input  logic            wr_bit,
    input  logic            host_we,
    input  logic [BITS-1:0] host_wdata,
    output logic            m,
    output logic            eb,
    output logic [BITS-1:0] cur_word
);

    localparam logic [DW-1:0] LAST_DIGIT = DW'(BITS - 1);

    logic [BITS-1:0] mem [WORDS];

    logic            primed_q;
    logic [BITS-1:0] cur_q, cur_d;
    logic [BITS-1:0] nxt_q, nxt_d;
    logic            m_q, m_d;
    logic            eb_q, eb_d;
    logic [BITS-1:0] cur_src, nxt_src, wb_word;
    logic [DW-1:0]   dig1, dig2;
    logic            last;

    always_comb begin
        // Until the first strobe after reset the buffers are stale; read the RAM directly.
        cur_src  = primed_q ? cur_q : mem[word];
        nxt_src  = primed_q ? nxt_q : mem[word_nxt];
        cur_word = cur_src;
        if (wr_en) begin
            cur_word[digit] = wr_bit;
        end
        wb_word = host_we ? host_wdata : cur_word;
        last    = (digit == LAST_DIGIT);
        dig1    = digit + DW'(1);
        dig2    = digit + DW'(2);

        if (last) begin
            cur_d = nxt_src;
            // With two words the prefetch target is the word being written back this edge.
            nxt_d = (word_nxt2 == word) ? wb_word : mem[word_nxt2];
            m_d   = nxt_src[0];
            eb_d  = nxt_src[1];
        end else begin
            cur_d = cur_word;
            nxt_d = nxt_src;
            m_d   = cur_word[dig1];
            eb_d  = (dig1 == LAST_DIGIT) ? nxt_src[0] : cur_word[dig2];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed_q <= 1'b0;
            cur_q    <= '0;
            nxt_q    <= '0;
            m_q      <= 1'b0;
            eb_q     <= 1'b0;
        end else if (bit_en) begin
            primed_q <= 1'b1;
            cur_q    <= cur_d;
            nxt_q    <= nxt_d;
            m_q      <= m_d;
            eb_q     <= eb_d;
        end
    end

    always_ff @(posedge clk) begin
        if (bit_en && last && !rst) begin
            mem[word] <= wb_word;
        end
    end

    assign m  = m_q;
    assign eb = eb_q;

endmodule

// File: rtl/mem_line_bank.sv
// Bank of G-15 recirculating drum lines: position counter, serial write decode, host load/inspect port.
//   state      | meaning
//   H_IDLE     | no request held; latch one when ld_req is high
//   H_PENDING  | request held; wait for its word's last digit (abort if ld_req drops)
//   H_ACK      | ld_ack high for this CLOCK, ld_rdata valid
//   H_WAIT_LOW | ack given; wait for ld_req to go low before accepting another
module mem_line_bank
    import g15_mem_pkg::*;
#(
    parameter int LINES = 4,
    parameter int WORDS = G15_LONG_WORDS,
    parameter int BITS  = G15_BITS,
    parameter int LW    = idx_width(LINES),
    parameter int WW    = idx_width(WORDS),
    parameter int DW    = idx_width(BITS)
) (
    input  logic             CLOCK,
    input  logic             rst,
    input  logic             BIT_EN,
    input  logic             wr_en,
    input  logic [LW-1:0]    wr_line,
    input  logic             wr_bit,
    output logic [LINES-1:0] M,
    output logic [LINES-1:0] EB,
    output logic [DW-1:0]    digit,
    output logic [WW-1:0]    word,
    input  logic             ld_req,
    input  logic             ld_we,
    input  logic [LW-1:0]    ld_line,
    input  logic [WW-1:0]    ld_word,
    input  logic [BITS-1:0]  ld_wdata,
    output logic             ld_ack,
    output logic [BITS-1:0]  ld_rdata
);

    localparam logic [DW-1:0] LAST_DIGIT = DW'(BITS - 1);
    localparam logic [WW-1:0] LAST_WORD  = WW'(WORDS - 1);

    typedef struct packed {
        logic            we;
        logic [LW-1:0]   line;
        logic [WW-1:0]   word;
        logic [BITS-1:0] wdata;
    } req_t;

    logic [DW-1:0]   digit_q, digit_d;
    logic [WW-1:0]   word_q, word_d;
    logic [WW-1:0]   word_nxt, word_nxt2;
    host_state_e     state_q, state_d;
    req_t            req_q, req_d;
    logic [BITS-1:0] rdata_q, rdata_d;
    logic            service;
    logic [BITS-1:0] rd_sel;
    logic [LINES-1:0] wr_en_l, host_we_l;
    logic [BITS-1:0] cur_word [LINES];

    always_comb begin
        word_nxt  = (word_q == LAST_WORD) ? '0 : word_q + WW'(1);
        word_nxt2 = (word_nxt == LAST_WORD) ? '0 : word_nxt + WW'(1);
        digit_d   = digit_q;
        word_d    = word_q;
        if (BIT_EN) begin
            if (digit_q == LAST_DIGIT) begin
                digit_d = '0;
                word_d  = word_nxt;
            end else begin
                digit_d = digit_q + DW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        service = 1'b0;
        case (state_q)
            H_IDLE: begin
                if (ld_req) begin
                    req_d.we    = ld_we;
                    req_d.line  = ld_line;
                    req_d.word  = ld_word;
                    req_d.wdata = ld_wdata;
                    state_d     = H_PENDING;
                end
            end
            H_PENDING: begin
                if (!ld_req) begin
                    state_d = H_IDLE;
                end else if (BIT_EN && digit_q == LAST_DIGIT && word_q == req_q.word) begin
                    service = 1'b1;
                    state_d = H_ACK;
                end
            end
            H_ACK:      state_d = ld_req ? H_WAIT_LOW : H_IDLE;
            H_WAIT_LOW: if (!ld_req) state_d = H_IDLE;
            default:    state_d = H_IDLE;
        endcase
    end

    // Line selects; an out-of-range line matches nothing, so it reads 0 and writes nothing.
    always_comb begin
        rd_sel    = '0;
        wr_en_l   = '0;
        host_we_l = '0;
        for (int l = 0; l < LINES; l++) begin
            wr_en_l[l]   = wr_en && (wr_line == LW'(l));
            host_we_l[l] = service && req_q.we && (req_q.line == LW'(l));
            if (req_q.line == LW'(l)) begin
                rd_sel = cur_word[l];
            end
        end
        rdata_d = service ? rd_sel : rdata_q;
    end

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            digit_q <= '0;
            word_q  <= '0;
            state_q <= H_IDLE;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            digit_q <= digit_d;
            word_q  <= word_d;
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
        end
    end

    for (genvar g = 0; g < LINES; g++) begin : g_line
        mem_line #(
            .WORDS (WORDS),
            .BITS  (BITS),
            .WW    (WW),
            .DW    (DW)
        ) u_line (
            .clk        (CLOCK),
            .rst        (rst),
            .bit_en     (BIT_EN),
            .digit      (digit_q),
            .word       (word_q),
            .word_nxt   (word_nxt),
            .word_nxt2  (word_nxt2),
            .wr_en      (wr_en_l[g]),
            .wr_bit     (wr_bit),
            .host_we    (host_we_l[g]),
            .host_wdata (req_q.wdata),
            .m          (M[g]),
            .eb         (EB[g]),
            .cur_word   (cur_word[g])
        );
    end

    assign digit    = digit_q;
    assign word     = word_q;
    assign ld_ack   = (state_q == H_ACK);
    assign ld_rdata = rdata_q;

endmodule

// File: tb/tb_mem_line_bank.sv
// Directed bench for mem_line_bank (2 lines x 4 words x 5 bits) with a bit-level memory model.
module tb_mem_line_bank;

    localparam int LINES = 2;
    localparam int WORDS = 4;
    localparam int BITS  = 5;
    localparam int LW    = 1;
    localparam int WW    = 2;
    localparam int DW    = 3;

    logic             CLOCK = 1'b0;
    logic             rst;
    logic             BIT_EN;
    logic             wr_en;
    logic [LW-1:0]    wr_line;
    logic             wr_bit;
    logic [LINES-1:0] M, EB;
    logic [DW-1:0]    digit;
    logic [WW-1:0]    word;
    logic             ld_req, ld_we;
    logic [LW-1:0]    ld_line;
    logic [WW-1:0]    ld_word;
    logic [BITS-1:0]  ld_wdata;
    logic             ld_ack;
    logic [BITS-1:0]  ld_rdata;

    always #5 CLOCK = ~CLOCK;

    mem_line_bank #(
        .LINES(LINES), .WORDS(WORDS), .BITS(BITS), .LW(LW), .WW(WW), .DW(DW)
    ) dut (
        .CLOCK(CLOCK), .rst(rst), .BIT_EN(BIT_EN),
        .wr_en(wr_en), .wr_line(wr_line), .wr_bit(wr_bit),
        .M(M), .EB(EB), .digit(digit), .word(word),
        .ld_req(ld_req), .ld_we(ld_we), .ld_line(ld_line), .ld_word(ld_word),
        .ld_wdata(ld_wdata), .ld_ack(ld_ack), .ld_rdata(ld_rdata)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [BITS-1:0] mdl [LINES][WORDS];
    int  pos_w, pos_d;
    bit  primed, known;
    bit  h_pend, h_we;
    int  h_line, h_word;
    logic [BITS-1:0] h_wdata;
    bit  exp_ack;

    typedef struct {
        bit              chk;
        logic [BITS-1:0] data;
    } sb_t;
    sb_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LINES-1:0] exp_bits(input int w, input int d);
        logic [LINES-1:0] r;
        for (int l = 0; l < LINES; l++) r[l] = mdl[l][w][d];
        return r;
    endfunction

    function automatic logic [LINES-1:0] exp_early(input int w, input int d);
        int nw, nd;
        nw = w;
        nd = d + 1;
        if (nd == BITS) begin
            nd = 0;
            nw = (w + 1) % WORDS;
        end
        return exp_bits(nw, nd);
    endfunction

    // One CLOCK; with en the model applies serial write, host service and advances position.
    task automatic tick(input bit en);
        sb_t e;
        exp_ack = 1'b0;
        BIT_EN  = en;
        if (h_pend && !ld_req) h_pend = 1'b0;
        if (en) begin
            if (wr_en) mdl[wr_line][pos_w][pos_d] = wr_bit;
            if (h_pend && ld_req && pos_d == BITS - 1 && pos_w == h_word) begin
                e.chk  = known;
                e.data = (h_line < LINES) ? mdl[h_line][pos_w] : '0;
                sb_q.push_back(e);
                if (h_we && h_line < LINES) mdl[h_line][pos_w] = h_wdata;
                h_pend  = 1'b0;
                exp_ack = 1'b1;
            end
            pos_d++;
            if (pos_d == BITS) begin
                pos_d = 0;
                pos_w = (pos_w + 1) % WORDS;
            end
            primed = 1'b1;
        end
        @(posedge CLOCK);
        #1;
        check("digit", digit, pos_d);
        check("word", word, pos_w);
        if (!primed || known) begin
            check("M", M, primed ? exp_bits(pos_w, pos_d) : '0);
            check("EB", EB, primed ? exp_early(pos_w, pos_d) : '0);
        end
        check("ld_ack", ld_ack, exp_ack);
        if (ld_ack === 1'b1) begin
            check("ack_has_expect", (sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.chk) check("ld_rdata", ld_rdata, e.data);
            end
        end
    endtask

    task automatic advance_to(input int w, input int d);
        int n;
        n = 0;
        wr_en = 1'b0;
        while (!(pos_w == w && pos_d == d) && n < 2 * WORDS * BITS) begin
            tick(1'b1);
            n++;
        end
        check("advance_reached", (pos_w == w && pos_d == d), 1);
    endtask

    task automatic host_access(input bit we, input int line, input int wrd,
                               input logic [BITS-1:0] wdata, input int ser_word, input int hold);
        int  budget;
        bit  seen;
        ld_req   = 1'b1;
        ld_we    = we;
        ld_line  = LW'(line);
        ld_word  = WW'(wrd);
        ld_wdata = wdata;
        wr_line  = LW'(line);
        wr_bit   = 1'b1;
        wr_en    = (ser_word >= 0 && pos_w == ser_word);
        tick(1'b1);
        h_pend  = 1'b1;
        h_we    = we;
        h_line  = line;
        h_word  = wrd;
        h_wdata = wdata;
        seen    = 1'b0;
        budget  = 0;
        while (!seen && budget < 2 * WORDS * BITS) begin
            wr_en = (ser_word >= 0 && pos_w == ser_word);
            tick(1'b1);
            budget++;
            seen = exp_ack || (ld_ack === 1'b1);
        end
        check("ack_within_budget", seen, 1);
        check("ack_word", word, (wrd + 1) % WORDS);
        check("ack_digit", digit, 0);
        wr_en = 1'b0;
        repeat (hold) tick(1'b1);
        ld_req = 1'b0;
        tick(1'b1);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        BIT_EN = 1'b1;
        #2;
        check("rst_digit", digit, 0);
        check("rst_word", word, 0);
        check("rst_M", M, 0);
        check("rst_EB", EB, 0);
        check("rst_ld_ack", ld_ack, 0);
        check("rst_ld_rdata", ld_rdata, 0);
        repeat (2) @(posedge CLOCK);
        #1;
        rst    = 1'b0;
        BIT_EN = 1'b0;
        pos_w  = 0;
        pos_d  = 0;
        primed = 1'b0;
        h_pend = 1'b0;
        sb_q.delete();
        check("post_rst_digit", digit, 0);
        check("post_rst_word", word, 0);
        check("post_rst_M", M, 0);
        check("post_rst_EB", EB, 0);
    endtask

    logic [BITS-1:0] init_tab [LINES][WORDS];
    logic [BITS-1:0] pat;

    initial begin
        rst = 1'b0; BIT_EN = 1'b0; wr_en = 1'b0; wr_line = '0; wr_bit = 1'b0;
        ld_req = 1'b0; ld_we = 1'b0; ld_line = '0; ld_word = '0; ld_wdata = '0;
        known = 1'b0; primed = 1'b0; h_pend = 1'b0; pos_w = 0; pos_d = 0;
        init_tab[0][0] = 5'h0A; init_tab[0][1] = 5'h13; init_tab[0][2] = 5'h07; init_tab[0][3] = 5'h1C;
        init_tab[1][0] = 5'h11; init_tab[1][1] = 5'h05; init_tab[1][2] = 5'h12; init_tab[1][3] = 5'h08;
        #3;
        do_reset();

        // Load every word through the host port; the stream becomes predictable afterwards.
        for (int l = 0; l < LINES; l++)
            for (int w = 0; w < WORDS; w++)
                host_access(1'b1, l, w, init_tab[l][w], -1, 0);
        known = 1'b1;

        // Strobe gating and wrap: one idle CLOCK between strobes, a full revolution.
        for (int i = 0; i < WORDS * BITS; i++) begin
            tick(1'b1);
            tick(1'b0);
        end

        // Serial write to line 1 word 2, then one full revolution showing the new bits.
        advance_to(2, 0);
        pat = 5'b01101;
        for (int d = 0; d < BITS; d++) begin
            wr_en   = 1'b1;
            wr_line = 1'b1;
            wr_bit  = pat[d];
            tick(1'b1);
        end
        wr_en = 1'b0;
        repeat (WORDS * BITS) tick(1'b1);
        host_access(1'b0, 1, 2, '0, -1, 0);

        // Revolution-boundary early bit.
        host_access(1'b1, 0, 0, 5'b00001, -1, 0);
        advance_to(3, 4);
        check("eb0_wrap", EB[0], 1);
        tick(1'b1);

        // Host write then read back, holding ld_req after the first ack.
        advance_to(1, 0);
        host_access(1'b1, 0, 3, 5'h15, -1, 2);
        host_access(1'b0, 0, 3, '0, -1, 0);

        // Conflict: serial ones and host zero to line 1 word 1 in the same word time.
        advance_to(0, 0);
        host_access(1'b1, 1, 1, 5'h00, 1, 0);
        host_access(1'b0, 1, 1, '0, -1, 0);

        // Abort before service.
        advance_to(0, 0);
        ld_req = 1'b1; ld_we = 1'b1; ld_line = 1'b0; ld_word = 2'd2; ld_wdata = 5'h1F;
        tick(1'b1);
        h_pend = 1'b1; h_we = 1'b1; h_line = 0; h_word = 2; h_wdata = 5'h1F;
        repeat (3) tick(1'b1);
        ld_req = 1'b0;
        repeat (2 * WORDS * BITS) tick(1'b1);
        host_access(1'b0, 0, 2, '0, -1, 0);

        // Reset mid-stream; line contents survive.
        advance_to(2, 3);
        do_reset();
        tick(1'b0);
        tick(1'b1);
        repeat (7) tick(1'b1);
        host_access(1'b0, 1, 2, '0, -1, 0);
        host_access(1'b0, 0, 3, '0, -1, 0);
        host_access(1'b0, 0, 0, '0, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
